// File: rtl/trap_pkg.sv
// Shared constants, FSM state encoding and code-width helper for the trap controller.
package trap_pkg;

   // Exception cause codes (machine mode)
   localparam logic [3:0] EXC_INST_MISALIGN  = 4'd0;
   localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
   localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
   localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
   localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
   localparam logic [3:0] EXC_ECALL_M        = 4'd11;

   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } trap_state_e;

   // Exception codes need 4 bits; interrupt indices above 15 need a fifth.
   function automatic int cause_code_w(input int num_irq);
      return (num_irq > 16) ? 5 : 4;
   endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Commit-stage event bundle: exception flags and interrupt state fed to the priority encoder.
interface trap_controller_if #(
   parameter int NUM_IRQ = 16
);
   logic               instr_valid;
   logic               inst_addr_malign;
   logic               illegal_inst;
   logic               ebreak;
   logic               ecall;
   logic               load_addr_malign;
   logic               store_amo_addr_malign;
   logic [NUM_IRQ-1:0] irq_pending;
   logic [NUM_IRQ-1:0] irq_enable;
   logic               global_ie;

   modport master (
      output instr_valid, inst_addr_malign, illegal_inst, ebreak, ecall,
             load_addr_malign, store_amo_addr_malign,
             irq_pending, irq_enable, global_ie
   );

   modport slave (
      input  instr_valid, inst_addr_malign, illegal_inst, ebreak, ecall,
             load_addr_malign, store_amo_addr_malign,
             irq_pending, irq_enable, global_ie
   );
endinterface

// File: rtl/trap_prio_enc.sv
// Combinational winner selection: fixed exception priority, then lowest eligible interrupt.
module trap_prio_enc
   import trap_pkg::*;
#(
   parameter int NUM_IRQ = 16,
   parameter int CW      = cause_code_w(NUM_IRQ)
) (
   trap_controller_if.slave ev,
   output logic          exc_valid_o,
   output logic          irq_valid_o,
   output logic [CW-1:0] code_o
);

   logic [NUM_IRQ-1:0] irq_eligible;

   assign irq_eligible = ev.global_ie ? (ev.irq_pending & ev.irq_enable) : '0;

   always_comb begin
      exc_valid_o = 1'b0;
      irq_valid_o = 1'b0;
      code_o      = '0;
      if (ev.instr_valid) begin
         exc_valid_o = 1'b1;
         if (ev.inst_addr_malign) begin
            code_o = CW'(EXC_INST_MISALIGN);
         end else if (ev.illegal_inst) begin
            code_o = CW'(EXC_ILLEGAL);
         end else if (ev.ebreak) begin
            code_o = CW'(EXC_BREAKPOINT);
         end else if (ev.ecall) begin
            code_o = CW'(EXC_ECALL_M);
         end else if (ev.load_addr_malign) begin
            code_o = CW'(EXC_LOAD_MISALIGN);
         end else if (ev.store_amo_addr_malign) begin
            code_o = CW'(EXC_STORE_MISALIGN);
         end else begin
            exc_valid_o = 1'b0;
         end

         // Scanning downward lets the lowest eligible index be the last writer.
         if (!exc_valid_o) begin
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
               if (irq_eligible[i]) begin
                  irq_valid_o = 1'b1;
                  code_o      = CW'(i);
               end
            end
         end
      end
   end

endmodule

// File: rtl/trap_controller.sv
// Commit-stage trap/MRET sequencer: arbitrates events, drains the pipeline, then redirects fetch.
// Define TRAP_VECTORED_EN to use base + 4*code interrupt targets when mtvec mode is 2'b01.
module trap_controller
   import trap_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_IRQ = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               instr_valid_i,
   input  logic [XLEN-1:0]    exc_pc_i,
   input  logic [XLEN-1:0]    exc_tval_i,
   input  logic               inst_addr_malign_i,
   input  logic               illegal_inst_i,
   input  logic               ebreak_i,
   input  logic               ecall_i,
   input  logic               load_addr_malign_i,
   input  logic               store_amo_addr_malign_i,
   input  logic [NUM_IRQ-1:0] irq_pending_i,
   input  logic [NUM_IRQ-1:0] irq_enable_i,
   input  logic               global_ie_i,
   input  logic [XLEN-1:0]    mtvec_i,
   input  logic [XLEN-1:0]    mepc_i,
   input  logic               mret_i,
   output logic               flush_req_o,
   input  logic               flush_ack_i,
   output logic               redirect_valid_o,
   output logic [XLEN-1:0]    redirect_pc_o,
   output logic               busy_o,
   output logic               trap_commit_o,
   output logic [XLEN-1:0]    trap_cause_o,
   output logic [XLEN-1:0]    trap_epc_o,
   output logic [XLEN-1:0]    trap_tval_o,
   output logic [1:0]         dbg_state_o
);

   localparam int CW = cause_code_w(NUM_IRQ);

   // Flush handshake: flush_req_o is held high for every FLUSH cycle; the pipeline
   // raises flush_ack_i once drained, and the first cycle both are high completes
   // the transfer. flush_ack_i is don't-care outside FLUSH.

   trap_state_e     state_q, state_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] tval_q, tval_d;
   logic [XLEN-1:0] target_q, target_d;
   logic            is_mret_q, is_mret_d;

   logic            exc_win, irq_win, mret_take, take;
   logic [CW-1:0]   win_code;
   logic [XLEN-1:0] trap_base, trap_target;

   trap_controller_if #(.NUM_IRQ(NUM_IRQ)) ev_bus ();

   assign ev_bus.instr_valid           = instr_valid_i;
   assign ev_bus.inst_addr_malign      = inst_addr_malign_i;
   assign ev_bus.illegal_inst          = illegal_inst_i;
   assign ev_bus.ebreak                = ebreak_i;
   assign ev_bus.ecall                 = ecall_i;
   assign ev_bus.load_addr_malign      = load_addr_malign_i;
   assign ev_bus.store_amo_addr_malign = store_amo_addr_malign_i;
   assign ev_bus.irq_pending           = irq_pending_i;
   assign ev_bus.irq_enable            = irq_enable_i;
   assign ev_bus.global_ie             = global_ie_i;

   trap_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .CW      (CW)
   ) u_prio_enc (
      .ev          (ev_bus),
      .exc_valid_o (exc_win),
      .irq_valid_o (irq_win),
      .code_o      (win_code)
   );

   // MRET only wins when nothing else is reported in the same commit slot.
   assign mret_take = instr_valid_i & mret_i & ~exc_win & ~irq_win;
   assign take      = exc_win | irq_win | mret_take;
   assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   always_comb begin
      trap_target = trap_base;
      if (irq_win && (mtvec_i[1:0] == MTVEC_VECTORED)) begin
         trap_target = trap_base + (XLEN'(win_code) << 2);
      end
   end
`else
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^mtvec_i[1:0];
   assign trap_target       = trap_base;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (take) state_d = ST_FLUSH;
         ST_FLUSH:    if (flush_ack_i) state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      flush_req_o      = 1'b0;
      busy_o           = 1'b0;
      redirect_valid_o = 1'b0;
      trap_commit_o    = 1'b0;
      case (state_q)
         ST_FLUSH: begin
            flush_req_o = 1'b1;
            busy_o      = 1'b1;
         end
         ST_REDIRECT: begin
            busy_o           = 1'b1;
            redirect_valid_o = 1'b1;
            trap_commit_o    = ~is_mret_q;
         end
         default: ;
      endcase
   end

   assign redirect_pc_o = target_q;
   assign trap_cause_o  = cause_q;
   assign trap_epc_o    = epc_q;
   assign trap_tval_o   = tval_q;
   assign dbg_state_o   = state_q;

   // Everything the redirect needs is sampled at the IDLE->FLUSH edge.
   always_comb begin
      cause_d   = cause_q;
      epc_d     = epc_q;
      tval_d    = tval_q;
      target_d  = target_q;
      is_mret_d = is_mret_q;
      if ((state_q == ST_IDLE) && take) begin
         epc_d     = exc_pc_i;
         is_mret_d = mret_take;
         cause_d   = '0;
         tval_d    = '0;
         target_d  = mepc_i;
         if (exc_win) begin
            cause_d  = XLEN'(win_code);
            tval_d   = exc_tval_i;
            target_d = trap_target;
         end else if (irq_win) begin
            cause_d            = XLEN'(win_code);
            cause_d[XLEN-1]    = 1'b1;
            target_d           = trap_target;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cause_q   <= '0;
         epc_q     <= '0;
         tval_q    <= '0;
         target_q  <= '0;
         is_mret_q <= 1'b0;
      end else begin
         cause_q   <= cause_d;
         epc_q     <= epc_d;
         tval_q    <= tval_d;
         target_q  <= target_d;
         is_mret_q <= is_mret_d;
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: drivers push expected redirects, a negedge monitor pops and compares.
module tb_trap_controller;

   localparam int XLEN    = 32;
   localparam int NUM_IRQ = 16;

   localparam logic [5:0] F_IAM   = 6'b100000;
   localparam logic [5:0] F_ILL   = 6'b010000;
   localparam logic [5:0] F_EBRK  = 6'b001000;
   localparam logic [5:0] F_ECALL = 6'b000100;
   localparam logic [5:0] F_LD    = 6'b000010;
   localparam logic [5:0] F_ST    = 6'b000001;

`ifdef TRAP_VECTORED_EN
   localparam logic [31:0] IRQ7_TGT  = 32'h0000_081C;
   localparam logic [31:0] IRQ15_TGT = 32'h0000_103C;
`else
   localparam logic [31:0] IRQ7_TGT  = 32'h0000_0800;
   localparam logic [31:0] IRQ15_TGT = 32'h0000_1000;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic        commit;
      logic [31:0] cause;
      logic [31:0] epc;
      logic [31:0] tval;
   } exp_t;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   trap_controller_if #(.NUM_IRQ(NUM_IRQ)) ev ();

   logic [XLEN-1:0] exc_pc, exc_tval, mtvec, mepc;
   logic            mret, flush_ack;
   logic            flush_req_o, redirect_valid_o, busy_o, trap_commit_o;
   logic [XLEN-1:0] redirect_pc_o, trap_cause_o, trap_epc_o, trap_tval_o;
   logic [1:0]      dbg_state_o;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   redirects = 0;
   int   flush_cycles = 0;

   trap_controller #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .instr_valid_i           (ev.instr_valid),
      .exc_pc_i                (exc_pc),
      .exc_tval_i              (exc_tval),
      .inst_addr_malign_i      (ev.inst_addr_malign),
      .illegal_inst_i          (ev.illegal_inst),
      .ebreak_i                (ev.ebreak),
      .ecall_i                 (ev.ecall),
      .load_addr_malign_i      (ev.load_addr_malign),
      .store_amo_addr_malign_i (ev.store_amo_addr_malign),
      .irq_pending_i           (ev.irq_pending),
      .irq_enable_i            (ev.irq_enable),
      .global_ie_i             (ev.global_ie),
      .mtvec_i                 (mtvec),
      .mepc_i                  (mepc),
      .mret_i                  (mret),
      .flush_req_o             (flush_req_o),
      .flush_ack_i             (flush_ack),
      .redirect_valid_o        (redirect_valid_o),
      .redirect_pc_o           (redirect_pc_o),
      .busy_o                  (busy_o),
      .trap_commit_o           (trap_commit_o),
      .trap_cause_o            (trap_cause_o),
      .trap_epc_o              (trap_epc_o),
      .trap_tval_o             (trap_tval_o),
      .dbg_state_o             (dbg_state_o)
   );

   function automatic void check(input string name, input logic [XLEN-1:0] got,
                                 input logic [XLEN-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin : mon
      exp_t e;
      logic ok;
      if (flush_req_o === 1'b1) flush_cycles++;
      if (redirect_valid_o === 1'b1) begin
         redirects++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_redirect pc=%h commit=%b", redirect_pc_o, trap_commit_o);
         end else begin
            e  = exp_q.pop_front();
            ok = (redirect_pc_o === e.pc) && (trap_commit_o === e.commit);
            if (e.commit) begin
               ok = ok && (trap_cause_o === e.cause) && (trap_epc_o === e.epc) &&
                    (trap_tval_o === e.tval);
            end
            if (!ok) begin
               n_err++;
               $display("FAIL redirect got pc=%h commit=%b cause=%h epc=%h tval=%h exp pc=%h commit=%b cause=%h epc=%h tval=%h",
                        redirect_pc_o, trap_commit_o, trap_cause_o, trap_epc_o, trap_tval_o,
                        e.pc, e.commit, e.cause, e.epc, e.tval);
            end
         end
      end
   end

   // driver tasks
   task automatic clear_ev();
      ev.instr_valid           = 1'b0;
      ev.inst_addr_malign      = 1'b0;
      ev.illegal_inst          = 1'b0;
      ev.ebreak                = 1'b0;
      ev.ecall                 = 1'b0;
      ev.load_addr_malign      = 1'b0;
      ev.store_amo_addr_malign = 1'b0;
      ev.irq_pending           = '0;
      ev.irq_enable            = '0;
      ev.global_ie             = 1'b0;
      mret                     = 1'b0;
   endtask

   task automatic set_ev(input logic [5:0] f, input logic [31:0] pc, input logic [31:0] tval,
                         input logic [15:0] pend, input logic [15:0] en, input logic mie,
                         input logic mr, input logic [31:0] mep, input logic [31:0] mtv);
      ev.instr_valid           = 1'b1;
      ev.inst_addr_malign      = f[5];
      ev.illegal_inst          = f[4];
      ev.ebreak                = f[3];
      ev.ecall                 = f[2];
      ev.load_addr_malign      = f[1];
      ev.store_amo_addr_malign = f[0];
      ev.irq_pending           = pend;
      ev.irq_enable            = en;
      ev.global_ie             = mie;
      mret                     = mr;
      exc_pc                   = pc;
      exc_tval                 = tval;
      mepc                     = mep;
      mtvec                    = mtv;
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic commit, input logic [31:0] cause,
                           input logic [31:0] epc, input logic [31:0] tval);
      exp_t e;
      e = '{pc: pc, commit: commit, cause: cause, epc: epc, tval: tval};
      exp_q.push_back(e);
   endtask

   // Capture the staged event, hold ack low for d FLUSH cycles, then wait for IDLE.
   task automatic fire(input string name, input int d, input bit noise);
      bit idle;
      @(posedge clk); #1;
      clear_ev();
      flush_cycles = 0;
      flush_ack    = (d == 0);
      if (noise) set_ev(F_ILL | F_ECALL, 32'hBAD0, 32'hBAD1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1,
                        32'h0BAD, 32'h0F00);
      for (int k = 1; k <= d; k++) begin
         @(posedge clk); #1;
         if (k == d) begin
            flush_ack = 1'b1;
            clear_ev();
         end
      end
      idle = 1'b0;
      for (int t = 0; t < 100 && !idle; t++) begin
         @(negedge clk);
         if (busy_o === 1'b0) idle = 1'b1;
      end
      flush_ack = 1'b0;
      check({name, "_idle"}, XLEN'(idle), 32'd1);
      check({name, "_flush_len"}, XLEN'(flush_cycles), XLEN'(d + 1));
   endtask

   task automatic expect_no_event(input string name);
      int r0;
      r0 = redirects;
      @(posedge clk); #1;
      clear_ev();
      repeat (4) @(negedge clk);
      check({name, "_redirects"}, XLEN'(redirects - r0), 32'd0);
      check({name, "_busy"}, XLEN'(busy_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_ev();
      exc_pc    = '0;
      exc_tval  = '0;
      mtvec     = '0;
      mepc      = '0;
      flush_ack = 1'b0;
      reset_n   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_flush_req", XLEN'(flush_req_o), 32'd0);
      check("rst_busy", XLEN'(busy_o), 32'd0);
      check("rst_redirect", XLEN'(redirect_valid_o), 32'd0);
      check("rst_commit", XLEN'(trap_commit_o), 32'd0);
      check("rst_cause", trap_cause_o, 32'd0);
      check("rst_state", XLEN'(dbg_state_o), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);

      // illegal beats load-misalign
      set_ev(F_ILL | F_LD, 32'h100, 32'hDEAD, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h800);
      push_exp(32'h800, 1'b1, 32'd2, 32'h100, 32'hDEAD);
      fire("illegal_load", 0, 1'b0);

      // irq 7 wins over pending-only irq 3
      set_ev(6'b0, 32'h200, 32'h1234, 16'h0088, 16'h0080, 1'b1, 1'b0, 32'h0, 32'h801);
      push_exp(IRQ7_TGT, 1'b1, 32'h8000_0007, 32'h200, 32'h0);
      fire("irq7", 1, 1'b0);

      // plain MRET: no commit pulse
      set_ev(6'b0, 32'h300, 32'h55, 16'h0, 16'h0, 1'b0, 1'b1, 32'h240, 32'h800);
      push_exp(32'h240, 1'b0, 32'h0, 32'h300, 32'h0);
      fire("mret", 0, 1'b0);

      // ecall with a stalled drain and noise during FLUSH
      set_ev(F_ECALL, 32'h400, 32'h0, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h800);
      push_exp(32'h800, 1'b1, 32'd11, 32'h400, 32'h0);
      fire("ecall_wait5", 5, 1'b1);

      // interrupt beats MRET, epc is the MRET PC
      set_ev(6'b0, 32'h500, 32'h99, 16'h0008, 16'h000F, 1'b1, 1'b1, 32'h240, 32'h800);
      push_exp(32'h800, 1'b1, 32'h8000_0003, 32'h500, 32'h0);
      fire("irq3_mret", 2, 1'b0);

      // exception beats MRET
      set_ev(F_EBRK, 32'h600, 32'h77, 16'h0, 16'h0, 1'b0, 1'b1, 32'h240, 32'h800);
      push_exp(32'h800, 1'b1, 32'd3, 32'h600, 32'h77);
      fire("ebreak_mret", 0, 1'b0);

      // priority ladder
      set_ev(6'b111111, 32'h610, 32'h1, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h800);
      push_exp(32'h800, 1'b1, 32'd0, 32'h610, 32'h1);
      fire("all_exc", 0, 1'b0);

      set_ev(F_EBRK | F_ECALL | F_ST, 32'h620, 32'h2, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h800);
      push_exp(32'h800, 1'b1, 32'd3, 32'h620, 32'h2);
      fire("ebreak_ecall", 0, 1'b0);

      set_ev(F_ECALL | F_LD, 32'h630, 32'h3, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h800);
      push_exp(32'h800, 1'b1, 32'd11, 32'h630, 32'h3);
      fire("ecall_load", 0, 1'b0);

      set_ev(F_LD | F_ST, 32'h640, 32'h4, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h800);
      push_exp(32'h800, 1'b1, 32'd4, 32'h640, 32'h4);
      fire("load_store", 0, 1'b0);

      // store exception beats an eligible interrupt
      set_ev(F_ST, 32'h650, 32'h5, 16'h0001, 16'h0001, 1'b1, 1'b0, 32'h0, 32'h801);
      push_exp(32'h800, 1'b1, 32'd6, 32'h650, 32'h5);
      fire("store_vs_irq", 1, 1'b0);

      set_ev(F_IAM, 32'h660, 32'h661, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h0C03);
      push_exp(32'h0C00, 1'b1, 32'd0, 32'h660, 32'h661);
      fire("iam_base_align", 0, 1'b0);

      // lowest eligible index, and the highest line
      set_ev(6'b0, 32'h700, 32'h0, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 32'h0, 32'h800);
      push_exp(32'h800, 1'b1, 32'h8000_0001, 32'h700, 32'h0);
      fire("irq_lowest", 0, 1'b0);

      set_ev(6'b0, 32'h710, 32'hABC, 16'h8000, 16'h8000, 1'b1, 1'b0, 32'h0, 32'h1001);
      push_exp(IRQ15_TGT, 1'b1, 32'h8000_000F, 32'h710, 32'h0);
      fire("irq15", 0, 1'b0);

      // non-events
      set_ev(6'b0, 32'h720, 32'h0, 16'h0001, 16'h0001, 1'b0, 1'b0, 32'h0, 32'h800);
      expect_no_event("mie_off");
      set_ev(F_ILL, 32'h730, 32'h0, 16'h0, 16'h0, 1'b0, 1'b1, 32'h240, 32'h800);
      ev.instr_valid = 1'b0;
      expect_no_event("not_valid");

      // reset during FLUSH aborts the sequence
      set_ev(F_ECALL, 32'h740, 32'h0, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h800);
      @(posedge clk); #1;
      clear_ev();
      flush_ack = 1'b0;
      @(negedge clk);
      check("abort_in_flush", XLEN'(flush_req_o), 32'd1);
      begin
         int r0;
         r0 = redirects;
         #1 reset_n = 1'b0;
         #1;
         check("abort_flush_req", XLEN'(flush_req_o), 32'd0);
         check("abort_busy", XLEN'(busy_o), 32'd0);
         check("abort_state", XLEN'(dbg_state_o), 32'd0);
         check("abort_cause", trap_cause_o, 32'd0);
         check("abort_epc", trap_epc_o, 32'd0);
         @(posedge clk); #1;
         flush_ack = 1'b1;
         @(posedge clk); #1;
         reset_n = 1'b1;
         repeat (5) @(negedge clk);
         check("abort_no_redirect", XLEN'(redirects - r0), 32'd0);
         check("abort_idle", XLEN'(busy_o), 32'd0);
         flush_ack = 1'b0;
      end

      // a normal event still works after the abort
      set_ev(F_ILL, 32'h750, 32'hF00D, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h900);
      push_exp(32'h900, 1'b1, 32'd2, 32'h750, 32'hF00D);
      fire("post_abort", 3, 1'b0);

      repeat (2) @(negedge clk);
      check("queue_drained", XLEN'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameters XLEN (default 32; cause, PC and tval width) and NUM_IRQ (default 16; legal range 1..32; interrupt line count).
REQ-002 SHALL have ports: clk in 1 (rising-edge clock); reset_n in 1 (asynchronous, active-low reset).
REQ-003 SHALL have ports: instr_valid_i in 1 (commit-stage instruction valid); exc_pc_i in XLEN (commit PC); exc_tval_i in XLEN (faulting address/instruction).
REQ-004 SHALL have ports: inst_addr_malign_i, illegal_inst_i, ebreak_i, ecall_i, load_addr_malign_i, store_amo_addr_malign_i, each in 1 (commit exception flags).
REQ-005 SHALL have ports: irq_pending_i in NUM_IRQ (mip); irq_enable_i in NUM_IRQ (mie); global_ie_i in 1 (mstatus.MIE).
REQ-006 SHALL have ports: mtvec_i in XLEN; mepc_i in XLEN; mret_i in 1 (commit instruction is MRET).
REQ-007 SHALL have ports: flush_req_o out 1; flush_ack_i in 1 (pipeline drained).
REQ-008 SHALL have ports: redirect_valid_o out 1; redirect_pc_o out XLEN; busy_o out 1.
REQ-009 SHALL have ports: trap_commit_o out 1 (CSR latch strobe); trap_cause_o out XLEN; trap_epc_o out XLEN; trap_tval_o out XLEN.

Function
REQ-010 SHALL evaluate events only in IDLE when instr_valid_i=1; event inputs SHALL be ignored in FLUSH and REDIRECT.
REQ-011 Exception priority SHALL be: inst_addr_malign (0) > illegal (2) > ebreak (3) > ecall (11) > load_malign (4) > store_malign (6).
REQ-012 An interrupt SHALL be eligible when global_ie_i=1 and irq_pending_i[i]&irq_enable_i[i]; the lowest eligible index wins; cause = {1'b1, code i}.
REQ-013 Arbitration SHALL be: any exception > eligible interrupt > mret_i.
REQ-014 FSM SHALL have states IDLE, FLUSH and REDIRECT; IDLE->FLUSH on a winning event; FLUSH->REDIRECT on the first cycle flush_ack_i=1; REDIRECT->IDLE unconditionally after 1 cycle.
REQ-015 On IDLE->FLUSH, cause, epc (=exc_pc_i), tval, target and a trap/mret kind flag SHALL be registered; for an interrupt, tval SHALL be 0.
REQ-016 flush_req_o SHALL be 1 for every cycle in FLUSH; busy_o SHALL be 1 in FLUSH and REDIRECT.
REQ-017 In REDIRECT, redirect_valid_o SHALL pulse for 1 cycle with redirect_pc_o set to the registered target.
REQ-018 In REDIRECT, trap_commit_o SHALL pulse for traps only, never for mret, with trap_cause_o/epc/tval held from capture.
REQ-019 The trap target SHALL be {mtvec_i[XLEN-1:2],2'b00}; the mret target SHALL be mepc_i; both SHALL be sampled at capture.
REQ-020 Minimum latency from event to redirect SHALL be 2 cycles (ack already high in the first FLUSH cycle); there SHALL be no upper bound while flush_ack_i stays 0.
REQ-021 Interrupt and mret in the same cycle SHALL take the interrupt with epc = PC of the MRET.
REQ-022 An exception with mret in the same cycle SHALL take the exception.

Reset
REQ-023 While reset_n=0, state SHALL be IDLE and all outputs and capture registers SHALL be 0, asynchronously.
REQ-024 Reset asserted during FLUSH or REDIRECT SHALL abort the sequence with no redirect or commit pulse after release.

Configuration
REQ-025 With TRAP_VECTORED_EN defined and mtvec_i[1:0]=2'b01, interrupt target SHALL be base + 4*code; exceptions SHALL use base.
REQ-026 Without TRAP_VECTORED_EN, mtvec_i[1:0] SHALL be ignored and all traps SHALL use base.

Structure
REQ-027 Package trap_pkg SHALL hold exception code constants, the FSM state enum and the cause-width helper.
REQ-028 Combinational sub-module trap_prio_enc SHALL resolve the exception/interrupt winner and its code.

Verification
REQ-029 illegal_inst_i=1 and load_addr_malign_i=1, PC=0x100, tval=0xDEAD, mtvec=0x800 -> after ack: redirect 0x800, cause 2, epc 0x100, tval 0xDEAD.
REQ-030 irq_pending=0x0088, enable=0x0080, MIE=1 -> cause 0x80000007, tval 0; with TRAP_VECTORED_EN and mtvec=0x801 -> redirect 0x81C.
REQ-031 mret_i=1, mepc=0x240 -> redirect 0x240, trap_commit_o stays 0.
REQ-032 ecall_i=1 with flush_ack_i held 0 for 5 cycles -> flush_req_o high for 6 cycles, then a single redirect pulse; new events during the wait are ignored.
REQ-033 reset_n low in FLUSH -> outputs 0 immediately, no redirect after release.
REQ-034 mret_i and irq[3] eligible together -> cause 0x80000003, epc = MRET PC.
